os_result_drain: RTL and testbench

Result unloader for the output-stationary MAC systolic array. On a tile-done pulse it snapshots the array's flat accumulator bus into a shadow buffer and issues a one-cycle `clc` so the array can start the next tile immediately. It then streams the tile out one array row per beat over a valid/ready interface. It sits between the array top and the output writer or DMA, and it is the only producer of `clc`.

---
 rtl/os_drain_pkg.sv | 19 +
 rtl/os_drain_conv.sv | 34 +++
 rtl/os_result_drain.sv | 98 +++++++++
 tb/tb_os_result_drain.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/os_drain_pkg.sv
// os_result_drain shared types, default widths and row-index sizing.
// Used by os_result_drain and os_drain_conv.
package os_drain_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  localparam int unsigned DEF_A_H = 16;
  localparam int unsigned DEF_B_W = 16;
  localparam int unsigned DEF_ACC_WIDTH = 32;
  localparam int unsigned DEF_OUT_WIDTH = 32;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/os_drain_conv.sv
// One accumulator element narrowed to the output width.
// OS_DRAIN_SAT_EN selects signed saturation; otherwise low bits are kept.
module os_drain_conv
  import os_drain_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] din,
  output logic [OUT_WIDTH-1:0] dout
);

  generate
    if (OUT_WIDTH == ACC_WIDTH) begin : g_id
      assign dout = din;
    end else begin : g_nar
`ifdef OS_DRAIN_SAT_EN
      localparam int HI = ACC_WIDTH - OUT_WIDTH + 1;
      logic in_range;
      // in range when every bit above the output sign matches it
      assign in_range =
        (din[ACC_WIDTH-1:OUT_WIDTH-1] == {HI{din[OUT_WIDTH-1]}});
      assign dout = in_range ? din[OUT_WIDTH-1:0]
                  : din[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
      logic unused_hi;
      assign unused_hi = ^din[ACC_WIDTH-1:OUT_WIDTH];
      assign dout = din[OUT_WIDTH-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/os_result_drain.sv
// Snapshots the systolic array result on done, pulses clc, streams rows.
// Build option OS_DRAIN_SAT_EN: saturate instead of truncate on narrowing.
module os_result_drain
  import os_drain_pkg::*;
#(
  parameter int A_H = DEF_A_H,
  parameter int B_W = DEF_B_W,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           done,
  input  logic [A_H*B_W*ACC_WIDTH-1:0]   result,
  output logic                           clc,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [B_W*OUT_WIDTH-1:0]       m_data,
  output logic [row_w(A_H)-1:0]          m_row,
  output logic                           m_last,
  output logic                           busy,
  output logic                           ovf,
  input  logic                           ovf_clr
);

  localparam int RW = row_w(A_H);
  localparam int ROW_BITS = B_W * ACC_WIDTH;
  localparam logic [RW-1:0] LAST_ROW = RW'(A_H - 1);

  drain_state_t                 state;
  logic [RW-1:0]                row;
  logic [A_H*ROW_BITS-1:0]      shadow;
  logic                         clc_q;
  logic                         ovf_q;
  logic [ROW_BITS-1:0]          row_acc;
  logic                         xfer;
  logic                         last_xfer;
  logic                         accept;

  assign xfer      = (state == STREAM) & m_ready;
  assign last_xfer = xfer & (row == LAST_ROW);
  assign accept    = done & ((state == IDLE) | last_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      shadow <= '0;
      clc_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      clc_q <= accept;
      if (accept) begin
        shadow <= result;
        row    <= '0;
        state  <= STREAM;
      end else if (last_xfer) begin
        row   <= '0;
        state <= IDLE;
      end else if (xfer) begin
        row <= row + RW'(1);
      end
      // a late done is dropped but remembered; set beats clear
      if (done & (state == STREAM) & ~last_xfer)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    row_acc = '0;
    for (int r = 0; r < A_H; r++)
      if (int'(row) == r)
        row_acc = shadow[r*ROW_BITS +: ROW_BITS];
  end

  genvar j;
  generate
    for (j = 0; j < B_W; j++) begin : g_conv
      os_drain_conv #(
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
      ) u_conv (
        .din (row_acc[j*ACC_WIDTH +: ACC_WIDTH]),
        .dout(m_data[j*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate

  assign clc     = clc_q;
  assign m_valid = (state == STREAM);
  assign busy    = (state == STREAM);
  assign m_row   = row;
  assign m_last  = (state == STREAM) & (row == LAST_ROW);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_os_result_drain.sv
// Directed bench for os_result_drain: 4x4 array, 32-bit acc, 16-bit out.
// Table of per-cycle vectors plus reset and narrowing sequences.
module tb_os_result_drain;

  localparam int AH = 4;
  localparam int BW = 4;
  localparam int ACC = 32;
  localparam int OUT = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   done;
  logic [AH*BW*ACC-1:0]   result;
  logic                   clc;
  logic                   m_valid;
  logic                   m_ready;
  logic [BW*OUT-1:0]      m_data;
  logic [1:0]             m_row;
  logic                   m_last;
  logic                   busy;
  logic                   ovf;
  logic                   ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  os_result_drain #(
    .A_H(AH), .B_W(BW), .ACC_WIDTH(ACC), .OUT_WIDTH(OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .result(result),
    .clc(clc), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_row(m_row), .m_last(m_last),
    .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic done;
    logic rdy;
    logic clr;
    int   res;
    logic clc;
    logic v;
    int   row;
    logic last;
    logic busy;
    logic ovf;
    int   tile;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(
    logic d, logic r, logic c, int res,
    logic e_clc, logic e_v, int e_row, logic e_last,
    logic e_busy, logic e_ovf, int e_tile);
    vec_t t;
    t.done = d; t.rdy = r; t.clr = c; t.res = res;
    t.clc = e_clc; t.v = e_v; t.row = e_row; t.last = e_last;
    t.busy = e_busy; t.ovf = e_ovf; t.tile = e_tile;
    return t;
  endfunction

  function automatic logic [AH*BW*ACC-1:0] mk_tile(int base);
    logic [AH*BW*ACC-1:0] t;
    t = '0;
    for (int i = 0; i < AH; i++)
      for (int j = 0; j < BW; j++)
        t[(i*BW+j)*ACC +: ACC] = 32'(base + 100*i + j);
    return t;
  endfunction

  function automatic logic [BW*OUT-1:0] exp_row(int base, int r);
    logic [BW*OUT-1:0] d;
    for (int j = 0; j < BW; j++)
      d[j*OUT +: OUT] = 16'(base + 100*r + j);
    return d;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, " clc"}, 64'(clc), 64'd0);
    check({tag, " valid"}, 64'(m_valid), 64'd0);
    check({tag, " data"}, 64'(m_data), 64'd0);
    check({tag, " row"}, 64'(m_row), 64'd0);
    check({tag, " last"}, 64'(m_last), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " ovf"}, 64'(ovf), 64'd0);
  endtask

  logic [63:0] sat_exp;
  logic [AH*BW*ACC-1:0] sat_tile;

  initial begin
    //                 done rdy clr res   clc v row last busy ovf tile
    tbl[0]  = mk(1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 5000, 1, 1, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 5000, 0, 1, 1, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 5000, 0, 1, 2, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 5000, 0, 1, 3, 1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 2000, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 5000, 1, 1, 0, 0, 1, 0, 2000);
    tbl[7]  = mk(0, 0, 0, 5000, 0, 1, 1, 0, 1, 0, 2000);
    tbl[8]  = mk(0, 0, 0, 5000, 0, 1, 1, 0, 1, 0, 2000);
    tbl[9]  = mk(0, 1, 0, 5000, 0, 1, 1, 0, 1, 0, 2000);
    tbl[10] = mk(0, 0, 0, 5000, 0, 1, 2, 0, 1, 0, 2000);
    tbl[11] = mk(0, 0, 0, 5000, 0, 1, 2, 0, 1, 0, 2000);
    tbl[12] = mk(0, 1, 0, 5000, 0, 1, 2, 0, 1, 0, 2000);
    tbl[13] = mk(0, 0, 0, 5000, 0, 1, 3, 1, 1, 0, 2000);
    tbl[14] = mk(0, 1, 0, 5000, 0, 1, 3, 1, 1, 0, 2000);
    tbl[15] = mk(1, 1, 0, 3000, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 4000, 1, 1, 0, 0, 1, 0, 3000);
    tbl[17] = mk(1, 1, 0, 4000, 0, 1, 1, 0, 1, 0, 3000);
    tbl[18] = mk(0, 1, 0, 4000, 0, 1, 2, 0, 1, 1, 3000);
    tbl[19] = mk(0, 1, 0, 4000, 0, 1, 3, 1, 1, 1, 3000);
    tbl[20] = mk(0, 1, 1, 4000, 0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(1, 1, 0, 7000, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 1, 0, 8000, 1, 1, 0, 0, 1, 0, 7000);
    tbl[23] = mk(0, 1, 0, 8000, 0, 1, 1, 0, 1, 0, 7000);
    tbl[24] = mk(0, 1, 0, 8000, 0, 1, 2, 0, 1, 0, 7000);
    tbl[25] = mk(1, 1, 0, 8000, 0, 1, 3, 1, 1, 0, 7000);
    tbl[26] = mk(0, 1, 0, 9000, 1, 1, 0, 0, 1, 0, 8000);
    tbl[27] = mk(1, 1, 1, 9000, 0, 1, 1, 0, 1, 0, 8000);
    tbl[28] = mk(0, 1, 0, 9000, 0, 1, 2, 0, 1, 1, 8000);
    tbl[29] = mk(0, 1, 0, 9000, 0, 1, 3, 1, 1, 1, 8000);
    tbl[30] = mk(0, 0, 1, 9000, 0, 0, 0, 0, 0, 1, 0);
    tbl[31] = mk(0, 0, 0, 9000, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    done = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    result = mk_tile(0);
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("v%0d clc", i), 64'(clc), 64'(tbl[i].clc));
      check($sformatf("v%0d valid", i), 64'(m_valid), 64'(tbl[i].v));
      check($sformatf("v%0d row", i), 64'(m_row), 64'(tbl[i].row));
      check($sformatf("v%0d last", i), 64'(m_last), 64'(tbl[i].last));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      check($sformatf("v%0d ovf", i), 64'(ovf), 64'(tbl[i].ovf));
      if (tbl[i].v)
        check($sformatf("v%0d data", i), 64'(m_data),
              64'(exp_row(tbl[i].tile, tbl[i].row)));
      done = tbl[i].done;
      m_ready = tbl[i].rdy;
      ovf_clr = tbl[i].clr;
      result = mk_tile(tbl[i].res);
    end

    // reset in the middle of a tile
    done = 1'b1;
    m_ready = 1'b1;
    ovf_clr = 1'b0;
    result = mk_tile(500);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid row2", 64'(m_row), 64'd2);
    check("mid data", 64'(m_data), 64'(exp_row(500, 2)));
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    done = 1'b1;
    result = mk_tile(600);
    @(negedge clk);
    done = 1'b0;
    check("post clc", 64'(clc), 64'd1);
    check("post row", 64'(m_row), 64'd0);
    check("post data", 64'(m_data), 64'(exp_row(600, 0)));
    repeat (4) @(negedge clk);
    check("post idle", 64'(busy), 64'd0);

    // narrowing of out-of-range values
    sat_tile = '0;
    sat_tile[0*ACC +: ACC] = 32'sd40000;
    sat_tile[1*ACC +: ACC] = -32'sd40000;
    sat_tile[2*ACC +: ACC] = 32'sd1234;
    sat_tile[3*ACC +: ACC] = -32'sd5;
`ifdef OS_DRAIN_SAT_EN
    sat_exp = {16'hFFFB, 16'd1234, 16'h8000, 16'h7FFF};
`else
    sat_exp = {16'hFFFB, 16'd1234, 16'h63C0, 16'h9C40};
`endif
    result = sat_tile;
    done = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    done = 1'b0;
    check("narrow valid", 64'(m_valid), 64'd1);
    check("narrow data", 64'(m_data), sat_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
